// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
//  - op_e   : 3-bit HI/LO-class op codes as presented by ID/EX
//  - state_e: sequencer states (idle, iterate, sign-fix/writeback)
//  - helpers classifying op codes
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MFHI  = 3'd6,
    OP_MFLO  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFix  = 2'd2
  } state_e;

  // Ops that start an iterative mul/div sequence.
  function automatic logic is_iter_op(input op_e op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic is_div_op(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Per-step unsigned datapath for the mul/div sequencer.
// Holds a double-width accumulator {acc_hi, acc_lo} and the second operand.
//  Mul: acc_lo starts as the multiplier, each step conditionally adds the multiplicand
//       into acc_hi and shifts the whole pair right by one.
//  Div: acc_lo starts as the dividend and fills with quotient bits from the right;
//       acc_hi is the partial remainder (restoring shift-subtract).
// Ports:
//  clk, rst        clock, synchronous active-high reset
//  load            capture a_abs/b_abs and clear the partial register
//  step            perform one iteration
//  is_div          selects divide step (else multiply step)
//  a_abs, b_abs    unsigned operand magnitudes
//  acc_hi, acc_lo  accumulator (product, or remainder/quotient)
module muldiv_iter import muldiv_pkg::*; #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            is_div,
  input  logic [XLEN-1:0] a_abs,
  input  logic [XLEN-1:0] b_abs,
  output logic [XLEN-1:0] acc_hi,
  output logic [XLEN-1:0] acc_lo
);

  logic [XLEN-1:0] acc_hi_q, acc_hi_d;
  logic [XLEN-1:0] acc_lo_q, acc_lo_d;
  logic [XLEN-1:0] opb_q, opb_d;

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_diff;

  always_comb begin
    // Multiply step: the add carry becomes the new top bit after the right shift.
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
    // Divide step: bring the next dividend bit into the partial remainder.
    div_shift = {acc_hi_q, acc_lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opb_q};
  end

  always_comb begin
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opb_d    = opb_q;
    if (load) begin
      acc_hi_d = '0;
      acc_lo_d = a_abs;
      opb_d    = b_abs;
    end else if (step) begin
      if (is_div) begin
        if (!div_diff[XLEN]) begin
          acc_hi_d = div_diff[XLEN-1:0];
          acc_lo_d = {acc_lo_q[XLEN-2:0], 1'b1};
        end else begin
          acc_hi_d = div_shift[XLEN-1:0];
          acc_lo_d = {acc_lo_q[XLEN-2:0], 1'b0};
        end
      end else begin
        acc_hi_d = mul_sum[XLEN:1];
        acc_lo_d = {mul_sum[0], acc_lo_q[XLEN-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opb_q    <= '0;
    end else begin
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opb_q    <= opb_d;
    end
  end

  assign acc_hi = acc_hi_q;
  assign acc_lo = acc_lo_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO register owner and mul/div sequencer sitting beside the EX-stage ALU.
// Accepts one HI/LO-class op per cycle; MULT/MULTU/DIV/DIVU iterate one bit per cycle
// (XLEN run cycles plus one sign-fix cycle) and any HI/LO op meeting a busy unit stalls.
// Ports:
//  clk, rst        clock, synchronous active-high reset
//  op_valid, op    HI/LO-class op from ID/EX
//  flush           squash the op presented this cycle
//  src_a, src_b    rs / rt operand values
//  stall           op not accepted this cycle (unit busy)
//  busy            iteration in progress
//  rd_data         HI (MFHI) / LO (MFLO) when accepted, else 0
//  hi, lo          architectural HI / LO
module muldiv_ctrl import muldiv_pkg::*; #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            op_valid,
  input  logic [2:0]      op,
  input  logic            flush,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            stall,
  output logic            busy,
  output logic [XLEN-1:0] rd_data,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int unsigned CntW = $clog2(XLEN + 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;

  // Per-operation context captured at accept.
  logic            is_div_q, is_div_d;
  logic            res_neg_q, res_neg_d;    // product/quotient sign
  logic            rem_neg_q, rem_neg_d;    // remainder follows dividend sign
  logic            div_zero_q, div_zero_d;
  logic [XLEN-1:0] a_raw_q, a_raw_d;

  op_e             op_dec;
  logic            accept;
  logic            start;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs;
  logic [XLEN-1:0] acc_hi, acc_lo;
  logic [2*XLEN-1:0] prod_raw, prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix;

  assign op_dec = op_e'(op);
  assign busy   = (state_q != StIdle);
  assign stall  = op_valid & ~flush & busy;
  assign accept = op_valid & ~flush & ~stall;
  assign start  = accept & is_iter_op(op_dec);

  // Magnitudes for the unsigned datapath; signed ops negate negative operands.
  assign a_neg = is_signed_op(op_dec) & src_a[XLEN-1];
  assign b_neg = is_signed_op(op_dec) & src_b[XLEN-1];
  assign a_abs = a_neg ? ('0 - src_a) : src_a;
  assign b_abs = b_neg ? ('0 - src_b) : src_b;

  muldiv_iter #(
    .XLEN (XLEN)
  ) u_iter (
    .clk    (clk),
    .rst    (rst),
    .load   (start),
    .step   (state_q == StRun),
    .is_div (is_div_q),
    .a_abs  (a_abs),
    .b_abs  (b_abs),
    .acc_hi (acc_hi),
    .acc_lo (acc_lo)
  );

  // Sign correction applied in the fix cycle.
  always_comb begin
    prod_raw = {acc_hi, acc_lo};
    prod_fix = res_neg_q ? ('0 - prod_raw) : prod_raw;
    quo_fix  = res_neg_q ? ('0 - acc_lo) : acc_lo;
    rem_fix  = rem_neg_q ? ('0 - acc_hi) : acc_hi;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    is_div_d   = is_div_q;
    res_neg_d  = res_neg_q;
    rem_neg_d  = rem_neg_q;
    div_zero_d = div_zero_q;
    a_raw_d    = a_raw_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StRun;
          cnt_d      = CntW'(XLEN);
          is_div_d   = is_div_op(op_dec);
          res_neg_d  = a_neg ^ b_neg;
          rem_neg_d  = a_neg;
          div_zero_d = (src_b == '0);
          a_raw_d    = src_a;
        end else if (accept && op_dec == OP_MTHI) begin
          hi_d = src_a;
        end else if (accept && op_dec == OP_MTLO) begin
          lo_d = src_a;
        end
      end
      StRun: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        state_d = StIdle;
        if (!is_div_q) begin
          hi_d = prod_fix[2*XLEN-1:XLEN];
          lo_d = prod_fix[XLEN-1:0];
        end else if (div_zero_q) begin
          // Divide by zero: no trap, fixed result regardless of signedness.
          hi_d = a_raw_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      is_div_q   <= 1'b0;
      res_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
      a_raw_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      is_div_q   <= is_div_d;
      res_neg_q  <= res_neg_d;
      rem_neg_q  <= rem_neg_d;
      div_zero_q <= div_zero_d;
      a_raw_q    <= a_raw_d;
    end
  end

  always_comb begin
    rd_data = '0;
    if (accept && op_dec == OP_MFHI) begin
      rd_data = hi_q;
    end else if (accept && op_dec == OP_MFLO) begin
      rd_data = lo_q;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed boundary cases plus randomized ops
// checked against a plain-arithmetic reference model.
module tb_muldiv_ctrl;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] C_MULT  = 3'd0;
  localparam logic [2:0] C_MULTU = 3'd1;
  localparam logic [2:0] C_DIV   = 3'd2;
  localparam logic [2:0] C_DIVU  = 3'd3;
  localparam logic [2:0] C_MTHI  = 3'd4;
  localparam logic [2:0] C_MTLO  = 3'd5;
  localparam logic [2:0] C_MFHI  = 3'd6;
  localparam logic [2:0] C_MFLO  = 3'd7;

  logic            clk = 1'b0;
  logic            rst;
  logic            op_valid;
  logic [2:0]      op;
  logic            flush;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            stall;
  logic            busy;
  logic [XLEN-1:0] rd_data;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  muldiv_ctrl #(
    .XLEN (XLEN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .op       (op),
    .flush    (flush),
    .src_a    (src_a),
    .src_b    (src_b),
    .stall    (stall),
    .busy     (busy),
    .rd_data  (rd_data),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: returns {hi, lo} from the architectural definition of each op.
  function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    longint          sa, sb, q, r, p;
    longint unsigned ua, ub, uq, ur, up;
    logic [63:0]     res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    res = '0;
    if (o == C_MULT) begin
      p = sa * sb;
      res = p;
    end else if (o == C_MULTU) begin
      up = ua * ub;
      res = up;
    end else if (b == 32'h0) begin
      res = {a, 32'hFFFF_FFFF};
    end else if (o == C_DIV) begin
      q = sa / sb;
      r = sa % sb;
      res = {r[31:0], q[31:0]};
    end else begin
      uq = ua / ub;
      ur = ua % ub;
      res = {ur[31:0], uq[31:0]};
    end
    return res;
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] pool [5];
    pool[0] = 32'h0;
    pool[1] = 32'h1;
    pool[2] = 32'hFFFF_FFFF;
    pool[3] = 32'h8000_0000;
    pool[4] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return pool[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a mul/div in the current cycle N and follow it to completion at N+XLEN+2.
  // hold_mf keeps MFLO presented during the busy window; noise randomizes
  // op_valid/op/flush/operands during the busy window.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit hold_mf, input bit noise);
    logic [63:0] res;
    res      = ref_op(o, a, b);
    op_valid = 1'b1;
    op       = o;
    src_a    = a;
    src_b    = b;
    flush    = 1'b0;
    #2;
    check_eq("start_stall", stall, 1'b0);
    tick();
    for (int i = 1; i <= XLEN + 1; i++) begin
      if (hold_mf) begin
        op_valid = 1'b1;
        op       = C_MFLO;
        flush    = 1'b0;
      end else if (noise) begin
        op_valid = 1'($urandom_range(0, 1));
        op       = 3'($urandom_range(0, 7));
        flush    = 1'($urandom_range(0, 1));
      end else begin
        op_valid = 1'b0;
        flush    = 1'b0;
      end
      src_a = $urandom;
      src_b = $urandom;
      #2;
      check_eq("busy_run", busy, 1'b1);
      check_eq("stall_run", stall, op_valid & ~flush);
      check_eq("rd_data_run", rd_data, 32'h0);
      check_eq("hi_hold", hi, exp_hi);
      check_eq("lo_hold", lo, exp_lo);
      tick();
    end
    exp_hi   = res[63:32];
    exp_lo   = res[31:0];
    op_valid = hold_mf;
    op       = C_MFLO;
    flush    = 1'b0;
    #2;
    check_eq("busy_done", busy, 1'b0);
    check_eq("hi_result", hi, exp_hi);
    check_eq("lo_result", lo, exp_lo);
    if (hold_mf) begin
      check_eq("mflo_stall", stall, 1'b0);
      check_eq("mflo_data", rd_data, exp_lo);
    end
    tick();
    op_valid = 1'b0;
  endtask

  task automatic move_to(input logic [2:0] o, input logic [31:0] a);
    op_valid = 1'b1;
    op       = o;
    src_a    = a;
    flush    = 1'b0;
    #2;
    check_eq("mt_stall", stall, 1'b0);
    tick();
    if (o == C_MTHI) exp_hi = a;
    else exp_lo = a;
    op_valid = 1'b0;
    #1;
    check_eq("mt_hi", hi, exp_hi);
    check_eq("mt_lo", lo, exp_lo);
  endtask

  task automatic move_from(input logic [2:0] o);
    op_valid = 1'b1;
    op       = o;
    flush    = 1'b0;
    src_a    = $urandom;
    #2;
    check_eq("mf_stall", stall, 1'b0);
    check_eq("mf_data", rd_data, (o == C_MFHI) ? exp_hi : exp_lo);
    tick();
    op_valid = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    op_valid = 1'b0;
    op       = 3'd0;
    flush    = 1'b0;
    src_a    = '0;
    src_b    = '0;
    exp_hi   = '0;
    exp_lo   = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_eq("rst_hi", hi, 32'h0);
    check_eq("rst_lo", lo, 32'h0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_stall", stall, 1'b0);
    check_eq("idle_rd_data", rd_data, 32'h0);

    // Directed arithmetic and boundary cases.
    run_op(C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check_eq("multu_max_hi", hi, 32'hFFFF_FFFE);
    check_eq("multu_max_lo", lo, 32'h0000_0001);
    run_op(C_DIV, 32'hFFFF_FFF9, 32'h2, 1'b0, 1'b0);
    check_eq("div_m7_2_lo", lo, 32'hFFFF_FFFD);
    check_eq("div_m7_2_hi", hi, 32'hFFFF_FFFF);
    run_op(C_DIVU, 32'h7, 32'h0, 1'b0, 1'b0);
    check_eq("divu_zero_lo", lo, 32'hFFFF_FFFF);
    check_eq("divu_zero_hi", hi, 32'h7);
    run_op(C_DIV, 32'hFFFF_FFF0, 32'h0, 1'b0, 1'b0);
    check_eq("div_zero_hi", hi, 32'hFFFF_FFF0);
    run_op(C_MULT, 32'h1234_5678, 32'hFEDC_BA98, 1'b1, 1'b0);
    run_op(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check_eq("div_ovf_lo", lo, 32'h8000_0000);
    check_eq("div_ovf_hi", hi, 32'h0);
    run_op(C_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    check_eq("mult_min_hi", hi, 32'h4000_0000);
    check_eq("mult_min_lo", lo, 32'h0);

    // MTHI then MFHI back to back, then a flushed MTLO.
    move_to(C_MTHI, 32'h1234);
    move_from(C_MFHI);
    op_valid = 1'b1;
    op       = C_MTLO;
    src_a    = 32'hDEAD_BEEF;
    flush    = 1'b1;
    #2;
    check_eq("flush_rd_data", rd_data, 32'h0);
    tick();
    flush    = 1'b0;
    op_valid = 1'b0;
    check_eq("flush_mtlo_lo", lo, exp_lo);

    // Flushed MULT at idle must not start.
    op_valid = 1'b1;
    op       = C_MULT;
    src_a    = 32'h3;
    src_b    = 32'h5;
    flush    = 1'b1;
    tick();
    op_valid = 1'b0;
    flush    = 1'b0;
    check_eq("flush_mult_busy", busy, 1'b0);

    // Reset in the middle of a DIV.
    move_to(C_MTLO, 32'h5555_AAAA);
    op_valid = 1'b1;
    op       = C_DIV;
    src_a    = 32'h7FFF_0000;
    src_b    = 32'h3;
    tick();
    op_valid = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    check_eq("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst    = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    #1;
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_hi", hi, 32'h0);
    check_eq("mid_rst_lo", lo, 32'h0);
    run_op(C_MULT, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0, 1'b0);

    // Randomized mix of all op classes.
    for (int n = 0; n < 40; n++) begin
      logic [2:0] o;
      o = 3'($urandom_range(0, 7));
      if (o <= C_DIVU) run_op(o, pick(), pick(), 1'($urandom_range(0, 1)), 1'b1);
      else if (o == C_MTHI || o == C_MTLO) move_to(o, pick());
      else move_from(o);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
